// File: rtl/dsp_result_round_sat.sv
// Shift / round-half-up / saturate stage for the signed DSP multiply-add result, with a 2-entry output buffer.
// Optional saturation counter port sat_count is enabled by defining DSP_RESULT_ROUND_SAT_STATS_EN.
module dsp_result_round_sat #(
    parameter int IN_W    = 38,
    parameter int OUT_W   = 20,
    parameter int SHIFT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_W-1:0]     in_data,
    input  logic [SHIFT_W-1:0]  shift_i,
    input  logic                round_en_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat,
    output logic                sat_sticky,
    input  logic                clear_sticky_i
`ifdef DSP_RESULT_ROUND_SAT_STATS_EN
    ,
    output logic [15:0]         sat_count
`endif
);

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;
    logic                 pos_ovf;
    logic                 neg_ovf;
    logic                 sat_now;
    logic [OUT_W-1:0]     sat_data;

    logic                 push;
    logic                 pop;
    logic [OUT_W-1:0]     mem_data [2];
    logic                 mem_sat  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;

    // One guard bit above the input keeps the rounding bias from overflowing.
    always_comb begin
        ext  = {in_data[IN_W-1], in_data};
        bias = '0;
        if (round_en_i && (shift_i != '0)) begin
            bias = (IN_W+1)'(1) << (shift_i - SHIFT_W'(1));
        end
        sum     = ext + bias;
        shifted = sum >>> shift_i;

        // Out of range whenever the bits above the output sign differ from the true sign.
        pos_ovf = !shifted[IN_W] && (|shifted[IN_W-1:OUT_W-1]);
        neg_ovf =  shifted[IN_W] && !(&shifted[IN_W-1:OUT_W-1]);
        sat_now = pos_ovf || neg_ovf;

        if (pos_ovf) begin
            sat_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (neg_ovf) begin
            sat_data = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_data = shifted[OUT_W-1:0];
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_sat   = mem_sat[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data <= '{default: '0};
            mem_sat  <= '{default: 1'b0};
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= sat_data;
                mem_sat[wr_ptr]  <= sat_now;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // A saturating push outranks a clear on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_sticky <= 1'b0;
        end else if (push && sat_now) begin
            sat_sticky <= 1'b1;
        end else if (clear_sticky_i) begin
            sat_sticky <= 1'b0;
        end
    end

`ifdef DSP_RESULT_ROUND_SAT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (push && sat_now) begin
            if (clear_sticky_i) begin
                sat_count <= 16'd1;
            end else if (sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end else if (clear_sticky_i) begin
            sat_count <= '0;
        end
    end
`endif

endmodule

// File: doc/dsp_result_round_sat.md
Name: dsp_result_round_sat

Overview:
- Downstream stage for the signed multiply-add DSP block.
- Consumes its 38-bit signed product/sum P.
- Applies a per-sample arithmetic right shift with optional round-half-up, then saturates to OUT_W bits.
- Delivers results through a 2-entry valid/ready output buffer, so backpressure never drops a sample.

Parameters:
- IN_W, 38: signed input width (matches upstream P).
- OUT_W, 20: signed output width; must satisfy OUT_W < IN_W.
- SHIFT_W, 4: width of shift_i; shift range is 0 .. 2^SHIFT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low.
- in_valid  input  1  in_data, shift_i and round_en_i are valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  IN_W  signed upstream result.
- shift_i  input  SHIFT_W  arithmetic right-shift amount.
- round_en_i  input  1  1 = round-half-up; 0 = truncate toward -inf.
- out_valid  output  1  out_data/out_sat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  signed shifted/rounded/saturated result.
- out_sat  output  1  this output sample was saturated.
- sat_sticky  output  1  a saturated sample has been accepted since the last clear.
- clear_sticky_i  input  1  synchronous clear of sat_sticky.

Behaviour:
- Reset (reset=0, asynchronous):
  - buffer count=0, out_valid=0, out_data=0, out_sat=0, sat_sticky=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all buffered entries.
- Accept: push occurs when in_valid && in_ready at the rising clk edge.
- Datapath (combinational before the push):
  - Sign-extend in_data to IN_W+1 bits.
  - If round_en_i=1 and shift_i>0, add 1<<(shift_i-1).
  - Arithmetic right shift by shift_i.
  - If round_en_i=0 or shift_i=0, the result is plain in_data>>>shift_i.
- Saturation:
  - If result > 2^(OUT_W-1)-1, out_data = 2^(OUT_W-1)-1 and out_sat=1.
  - If result < -2^(OUT_W-1), out_data = -2^(OUT_W-1) and out_sat=1.
  - Otherwise out_data = low OUT_W bits and out_sat=0.
- Buffer:
  - 2-entry FIFO of {out_data, out_sat}; the head drives the outputs.
  - out_valid = (count != 0).
  - Pop occurs when out_valid && out_ready.
- Latency: 1 cycle. A sample accepted at edge N is visible on out_valid/out_data after edge N.
- Throughput: 1 sample/cycle while out_ready=1.
- in_ready = (count != 2). It depends only on registered state; there is no combinational path from out_ready.
- Simultaneous push and pop at count=1: count stays 1 and order is preserved.
- At count=2, in_ready=0, so no push occurs even if a pop happens on that same edge.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- FIFO order is strictly first-in-first-out; pointers wrap modulo 2.
- Sticky flag:
  - sat_sticky is set on a push with the saturate condition true.
  - clear_sticky_i=1 clears it on the next edge.
  - Set and clear on the same edge: set wins (sat_sticky=1).

Optional Feature:
- Macro: DSP_RESULT_ROUND_SAT_STATS_EN.
- Defined:
  - Adds output port sat_count [15:0], which increments on every saturated push.
  - It saturates at 16'hFFFF and never wraps.
  - clear_sticky_i zeroes it, except that a push with saturation on the same edge loads 1.
  - Reset value is 0.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
1. Reset: 2 entries buffered with out_ready=0, then assert reset=0 -> out_valid=0, out_data=0, sat_sticky=0; after release in_ready=1 and nothing emerges.
2. Pass-through: in_data=10, shift_i=0, round_en_i=0, out_ready=1 -> one cycle later out_valid=1, out_data=10, out_sat=0.
3. Rounding with shift_i=1:
   - round_en_i=1: in_data=7 -> 4; in_data=-7 -> -3.
   - round_en_i=0: in_data=7 -> 3; in_data=-7 -> -4.
   - shift_i=15, round_en_i=1, in_data=2^37-1 -> no intermediate overflow, expected 2^22 saturated to 524287.
4. Saturation (OUT_W=20): in_data=600000, shift 0 -> 524287, out_sat=1, sat_sticky=1; in_data=-600000 -> -524288, out_sat=1.
5. Backpressure: out_ready=0, offer samples 1,2,3 -> 1 and 2 accepted, in_ready=0 with 3 held; raise out_ready -> outputs 1,2,3 in order, one per cycle, with no loss or duplication.
6. Sticky clear: clear_sticky_i=1 on the same edge as a saturating push -> sat_sticky stays 1; clear alone on the next edge -> 0. With DSP_RESULT_ROUND_SAT_STATS_EN, sat_count reads 1 after the first edge and 0 after the second.
